// File: rtl/prince_pkg.sv
// Shared PRINCE constants: nibble width and the forward/inverse S-box tables.
// Also used by the key schedule and the reference model.
package prince_pkg;

    localparam int unsigned NIB_W = 4;

    localparam logic [NIB_W-1:0] PRINCE_SBOX [16] = '{
        4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
        4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
    };

    localparam logic [NIB_W-1:0] PRINCE_SBOX_INV [16] = '{
        4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
        4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
    };

endpackage

// File: rtl/prince_sbox_nib.sv
// Single-nibble PRINCE substitution: S when dec_i=0, S^-1 when dec_i=1.
module prince_sbox_nib
    import prince_pkg::*;
(
    input  logic             dec_i,
    input  logic [NIB_W-1:0] a_i,
    output logic [NIB_W-1:0] y_o
);

    always_comb begin
        y_o = dec_i ? PRINCE_SBOX_INV[a_i] : PRINCE_SBOX[a_i];
    end

endmodule

// File: rtl/prince_sbox_layer.sv
// Pipelined PRINCE S-box layer: NIB parallel nibble substitutions captured into an
// elastic valid/ready pipeline of PIPE stages; the mode bit travels with each beat.
module prince_sbox_layer
    import prince_pkg::*;
#(
    parameter int unsigned NIB  = 16,
    parameter int unsigned PIPE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_dec,
    input  logic [NIB*NIB_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_dec,
    output logic [NIB*NIB_W-1:0] out_data
);

    localparam int unsigned W = NIB * NIB_W;

    logic [W-1:0]    sub_data;
    logic [PIPE-1:0] v_q;
    logic [PIPE-1:0] dec_q;
    logic [W-1:0]    dat_q [PIPE];
    logic [PIPE-1:0] adv;
    logic [PIPE-1:0] v_in;
    logic [PIPE-1:0] dec_in;
    logic [W-1:0]    dat_in [PIPE];

    for (genvar gi = 0; gi < NIB; gi++) begin : gen_nib
        prince_sbox_nib u_nib (
            .dec_i (in_dec),
            .a_i   (in_data[gi*NIB_W +: NIB_W]),
            .y_o   (sub_data[gi*NIB_W +: NIB_W])
        );
    end

    // adv[k] = !v[k] || adv[k+1], flattened so no signal feeds back on itself:
    // a stage advances if downstream is ready or any stage from k onward is empty.
    always_comb begin
        logic a;
        a   = 1'b0;
        adv = '0;
        for (int k = 0; k < PIPE; k++) begin
            a = out_ready;
            for (int j = k; j < PIPE; j++) begin
                a = a | ~v_q[j];
            end
            adv[k] = a;
        end
    end

    always_comb begin
        v_in      = '0;
        dec_in    = '0;
        v_in[0]   = in_valid;
        dec_in[0] = in_dec;
        dat_in[0] = sub_data;
        for (int k = 1; k < PIPE; k++) begin
            v_in[k]   = v_q[k-1];
            dec_in[k] = dec_q[k-1];
            dat_in[k] = dat_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            dec_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (flush) begin
                    v_q[k] <= 1'b0;
                end else if (adv[k]) begin
                    v_q[k] <= v_in[k];
                    // Bubbles leave the payload untouched.
                    if (v_in[k]) begin
                        dec_q[k] <= dec_in[k];
                        dat_q[k] <= dat_in[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v_q[PIPE-1];
    assign out_dec   = dec_q[PIPE-1];
    assign out_data  = dat_q[PIPE-1];

endmodule

// File: tb/tb_prince_sbox_layer.sv
// Scoreboard bench for prince_sbox_layer (NIB=16, PIPE=3): directed vectors, stall,
// flush, async reset and a short randomised stream checked against a table model.
module tb_prince_sbox_layer;

    localparam int unsigned NIB  = 16;
    localparam int unsigned PIPE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_dec;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_dec;
    logic [63:0] out_data;

    prince_sbox_layer #(
        .NIB  (NIB),
        .PIPE (PIPE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dec    (in_dec),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        dec;
        logic [63:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_lat = 1'b0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic d, input logic [63:0] x);
        logic [63:0] fw;
        logic [63:0] iv;
        logic [63:0] r;
        fw = 64'hBF32AC916780E5D4;
        iv = 64'hB732FD89A6405EC1;
        r  = '0;
        for (int i = 0; i < 16; i++) begin
            r[i*4 +: 4] = d ? iv[(15 - int'(x[i*4 +: 4]))*4 +: 4]
                            : fw[(15 - int'(x[i*4 +: 4]))*4 +: 4];
        end
        return r;
    endfunction

    // Monitor: output handshakes are evaluated late in the cycle, after inputs settled.
    always @(negedge clk) begin
        #3;
        if (rst_n && flush) begin
            sbq.delete();
        end else if (rst_n && out_valid && out_ready) begin
            exp_t e;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h, expected no beat", out_data);
            end else begin
                e = sbq.pop_front();
                check("beat", {out_dec, out_data}, {e.dec, e.data});
                if (chk_lat) check("latency", 65'(cyc - e.cyc), 65'(PIPE));
            end
        end
    end

    task automatic drive(input logic v, input logic d, input logic [63:0] data,
                         input logic [63:0] exp, input logic ordy, input logic fl,
                         output bit acc);
        @(negedge clk);
        in_valid  = v;
        in_dec    = d;
        in_data   = data;
        out_ready = ordy;
        flush     = fl;
        #2;
        acc = v && in_ready && rst_n;
        if (acc) sbq.push_back('{d, exp, cyc});
    endtask

    task automatic send(input logic d, input logic [63:0] data, input logic [63:0] exp,
                        output int tries);
        bit acc;
        tries = 0;
        do begin
            drive(1'b1, d, data, exp, 1'b1, 1'b0, acc);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready, expected acceptance");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        bit acc;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, acc);
            n++;
        end
        check("drain_empty", 65'(sbq.size()), 65'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic        bd   [6];
    logic [63:0] bdat [6];
    logic [63:0] bexp [6];

    initial begin
        int tries;
        int idx;
        bit acc;
        logic [63:0] held;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_dec = 1'b0;
        in_data = '0; out_ready = 1'b1;
        #12 rst_n = 1'b1;
        @(negedge clk); #2;
        check("rst_out_valid", 65'(out_valid), 65'd0);
        check("rst_out_dec", 65'(out_dec), 65'd0);
        check("rst_out_data", 65'(out_data), 65'd0);
        check("rst_in_ready", 65'(in_ready), 65'd1);

        // Directed enc/dec vectors with latency checking.
        chk_lat = 1'b1;
        send(1'b0, 64'h0123456789ABCDEF, 64'hBF32AC916780E5D4, tries);
        send(1'b1, 64'hBF32AC916780E5D4, 64'h0123456789ABCDEF, tries);
        send(1'b0, 64'hFEDCBA9876543210, 64'h4D5E087619CA23FB, tries);
        send(1'b1, 64'h0123456789ABCDEF, 64'hB732FD89A6405EC1, tries);
        drain();

        // Back-to-back alternating modes on zero input: no bubbles expected.
        for (int i = 0; i < 8; i++) begin
            send(i[0], 64'h0, 64'hBBBBBBBBBBBBBBBB, tries);
            check("b2b_tries", 65'(tries), 65'd1);
        end
        drain();

        // Output stall: only PIPE beats fit, head of line holds.
        chk_lat = 1'b0;
        bd[0] = 1'b0; bdat[0] = 64'h0123456789ABCDEF; bexp[0] = 64'hBF32AC916780E5D4;
        bd[1] = 1'b1; bdat[1] = 64'h0;                bexp[1] = 64'hBBBBBBBBBBBBBBBB;
        bd[2] = 1'b0; bdat[2] = 64'hFFFFFFFFFFFFFFFF; bexp[2] = 64'h4444444444444444;
        bd[3] = 1'b1; bdat[3] = 64'h4444444444444444; bexp[3] = 64'hFFFFFFFFFFFFFFFF;
        bd[4] = 1'b0; bdat[4] = 64'hFEDCBA9876543210; bexp[4] = 64'h4D5E087619CA23FB;
        bd[5] = 1'b1; bdat[5] = 64'hBF32AC916780E5D4; bexp[5] = 64'h0123456789ABCDEF;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, bd[idx], bdat[idx], bexp[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("stall_accepted", 65'(idx), 65'd3);
        check("stall_in_ready", 65'(in_ready), 65'd0);
        check("stall_out_valid", 65'(out_valid), 65'd1);
        check("stall_head", {out_dec, out_data}, {bd[0], bexp[0]});
        held = out_data;
        drive(1'b1, bd[idx], bdat[idx], bexp[idx], 1'b0, 1'b0, acc);
        if (acc) idx++;
        check("stall_hold", 65'(out_data), 65'(held));
        while (idx < 6) begin
            send(bd[idx], bdat[idx], bexp[idx], tries);
            idx++;
        end
        drain();

        // Flush with two beats in flight and a third presented.
        chk_lat = 1'b1;
        send(1'b0, 64'h0123456789ABCDEF, 64'hBF32AC916780E5D4, tries);
        send(1'b1, 64'h0, 64'hBBBBBBBBBBBBBBBB, tries);
        drive(1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h4444444444444444, 1'b1, 1'b1, acc);
        check("flush_in_ready", 65'(in_ready), 65'd0);
        idle(1);
        check("flush_out_valid", 65'(out_valid), 65'd0);
        idle(5);
        check("flush_queue", 65'(sbq.size()), 65'd0);
        send(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h4444444444444444, tries);
        drain();

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 4; i++) send(1'b1, 64'h4444444444444444, 64'hFFFFFFFFFFFFFFFF, tries);
        #2 rst_n = 1'b0;
        #1;
        sbq.delete();
        check("arst_out_valid", 65'(out_valid), 65'd0);
        check("arst_out_dec", 65'(out_dec), 65'd0);
        check("arst_out_data", 65'(out_data), 65'd0);
        in_valid = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        #1;
        check("arst_in_ready", 65'(in_ready), 65'd1);
        idle(4);

        // Randomised stream with random backpressure against the table model.
        chk_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic        rd;
            logic [63:0] rx;
            rd = 1'($urandom_range(0, 1));
            rx = {$urandom, $urandom};
            drive(1'($urandom_range(0, 1)), rd, rx, model(rd, rx),
                  1'($urandom_range(0, 1)), 1'b0, acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
